// File: rtl/audio_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : audio_pkg
//  Purpose  : Shared constants and types for the audio jitter buffer:
//             mid-scale sample value, playback FSM encoding and the
//             default parameter values used by the top level.
//  Revision : 1.0  initial release
// ============================================================================
package audio_pkg;

    // Mid-scale (silence) level for unsigned 8-bit audio.
    localparam logic [7:0] AUDIO_MID = 8'h80;

    localparam int DEF_ADDR_W        = 12;
    localparam int DEF_SAMPLE_PERIOD = 6250;
    localparam int DEF_PREFILL       = 512;

    typedef enum logic [0:0] {
        FILL = 1'b0,
        PLAY = 1'b1
    } fsm_t;

endpackage
`default_nettype wire

// File: rtl/audio_jitter_buffer_if.sv
`default_nettype none
// ============================================================================
//  Interface : audio_jitter_buffer_if
//  Purpose   : Bundles the audio byte stream from the splitter, the packet
//              end markers and the playback-side outputs of the buffer.
//  Signals   : audio_axiiv/audio_axiid  byte valid / byte
//              pkt_done / pkt_kill      end of packet: commit / discard
//              sample_out, sample_valid current sample, new-sample pulse
//              underrun, overflow       single-cycle event pulses
//              level                    committed occupancy (ADDR_W+1 bits)
//              pwm_out                  PWM rendering of sample_out
//  Modports  : slave  - the buffer itself
//              master - the stream source / sample consumer
//  Revision  : 1.0  initial release
// ============================================================================
interface audio_jitter_buffer_if #(
    parameter int ADDR_W = 12
) ();
    logic              audio_axiiv;
    logic [7:0]        audio_axiid;
    logic              pkt_done;
    logic              pkt_kill;
    logic [7:0]        sample_out;
    logic              sample_valid;
    logic              underrun;
    logic              overflow;
    logic [ADDR_W:0]   level;
    logic              pwm_out;

    modport slave (
        input  audio_axiiv, audio_axiid, pkt_done, pkt_kill,
        output sample_out, sample_valid, underrun, overflow, level, pwm_out
    );

    modport master (
        output audio_axiiv, audio_axiid, pkt_done, pkt_kill,
        input  sample_out, sample_valid, underrun, overflow, level, pwm_out
    );
endinterface
`default_nettype wire

// File: rtl/audio_fifo_ram.sv
`default_nettype none
// ============================================================================
//  Module   : audio_fifo_ram
//  Purpose  : Simple dual-port RAM, one write port and one read port with a
//             single registered read cycle; written to infer block RAM.
//  Ports    : clk                       clock
//             wr_en, wr_addr, wr_data   write port
//             rd_en, rd_addr, rd_data   read port (data valid 1 cycle later)
//  Revision : 1.0  initial release
// ============================================================================
module audio_fifo_ram #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [DATA_W-1:0] rd_data_q;

    // No reset on the array or read register so the tools map it to BRAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data_q <= mem[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule
`default_nettype wire

// File: rtl/audio_jitter_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : audio_jitter_buffer
//  Purpose  : Stages audio bytes per Ethernet packet (commit on pkt_done,
//             roll back on pkt_kill or overflow), absorbs burst jitter in a
//             BRAM FIFO with prefill, and plays bytes out as 8-bit samples
//             at one sample per SAMPLE_PERIOD clocks.
//  Ports    : clk  system clock
//             rst  synchronous reset, active low
//             bus  audio_jitter_buffer_if.slave (stream in, samples out)
//  Config   : AUDIO_PWM_EN - when defined, pwm_out carries a 256-clock
//             PWM of sample_out; otherwise pwm_out is tied low.
//  Revision : 1.0  initial release
// ============================================================================
module audio_jitter_buffer
    import audio_pkg::*;
#(
    parameter int ADDR_W        = DEF_ADDR_W,
    parameter int SAMPLE_PERIOD = DEF_SAMPLE_PERIOD,
    parameter int PREFILL       = DEF_PREFILL
) (
    input  logic                 clk,
    input  logic                 rst,
    audio_jitter_buffer_if.slave bus
);

    localparam int              PTR_W       = ADDR_W + 1;
    localparam int              CNT_W       = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
    localparam logic [CNT_W-1:0] TICK_LAST  = CNT_W'(SAMPLE_PERIOD - 1);
    localparam logic [PTR_W-1:0] FULL_LVL   = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [PTR_W-1:0] PREFILL_LVL = PTR_W'(PREFILL);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [PTR_W-1:0] wr_ptr_q,     wr_ptr_d;
    logic [PTR_W-1:0] commit_ptr_q, commit_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q,     rd_ptr_d;
    logic             pkt_bad_q,    pkt_bad_d;
    logic             overflow_q,   overflow_d;
    logic             underrun_q,   underrun_d;
    logic             sample_valid_q, sample_valid_d;
    logic [7:0]       sample_out_q, sample_out_d;
    logic             rd_pend_q,    rd_pend_d;
    logic [CNT_W-1:0] tick_cnt_q,   tick_cnt_d;
    fsm_t             state_q,      state_d;

    logic [PTR_W-1:0] level;
    logic [PTR_W-1:0] base_wr;
    logic [PTR_W-1:0] space_used;
    logic             tick;
    logic             ram_wr_en;
    logic             ram_rd_en;
    logic [7:0]       ram_rd_data;

    assign level = commit_ptr_q - rd_ptr_q;
    assign tick  = (tick_cnt_q == TICK_LAST);

    // ------------------------------------------------------------------
    // Write side: packet staging, commit and rollback.
    // End-of-packet decisions use the pre-write wr_ptr; a byte arriving
    // in the same cycle starts the next packet, so it is written at the
    // post-commit / post-rollback pointer (base_wr).
    // ------------------------------------------------------------------
    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        commit_ptr_d = commit_ptr_q;
        pkt_bad_d    = pkt_bad_q;
        overflow_d   = 1'b0;
        ram_wr_en    = 1'b0;
        base_wr      = wr_ptr_q;

        if (bus.pkt_done && !bus.pkt_kill && !pkt_bad_q) begin
            commit_ptr_d = wr_ptr_q;
        end
        if (bus.pkt_kill || (bus.pkt_done && pkt_bad_q)) begin
            base_wr = commit_ptr_q;
        end
        if (bus.pkt_done && pkt_bad_q) begin
            overflow_d = 1'b1;
        end
        if (bus.pkt_done || bus.pkt_kill) begin
            pkt_bad_d = 1'b0;
        end

        wr_ptr_d = base_wr;
        if (bus.audio_axiiv) begin
            if (space_used == FULL_LVL) begin
                // Dropping any byte poisons the whole packet.
                pkt_bad_d = 1'b1;
            end else begin
                ram_wr_en = 1'b1;
                wr_ptr_d  = base_wr + PTR_W'(1);
            end
        end
    end

    assign space_used = base_wr - rd_ptr_q;

    // ------------------------------------------------------------------
    // Read side: sample tick, FILL/PLAY control, output pipeline.
    // Tick at T issues the BRAM read; data lands in sample_out at T+2.
    // ------------------------------------------------------------------
    always_comb begin
        tick_cnt_d     = tick ? '0 : tick_cnt_q + CNT_W'(1);
        state_d        = state_q;
        rd_ptr_d       = rd_ptr_q;
        ram_rd_en      = 1'b0;
        rd_pend_d      = 1'b0;
        underrun_d     = 1'b0;
        sample_valid_d = 1'b0;
        sample_out_d   = sample_out_q;

        if (rd_pend_q) begin
            sample_out_d   = ram_rd_data;
            sample_valid_d = 1'b1;
        end

        case (state_q)
            FILL: begin
                if (level >= PREFILL_LVL) begin
                    state_d = PLAY;
                end
            end
            PLAY: begin
                if (tick) begin
                    if (level != '0) begin
                        ram_rd_en = 1'b1;
                        rd_ptr_d  = rd_ptr_q + PTR_W'(1);
                        rd_pend_d = 1'b1;
                    end else begin
                        underrun_d   = 1'b1;
                        sample_out_d = AUDIO_MID;
                        state_d      = FILL;
                    end
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q       <= '0;
            commit_ptr_q   <= '0;
            rd_ptr_q       <= '0;
            pkt_bad_q      <= 1'b0;
            overflow_q     <= 1'b0;
            underrun_q     <= 1'b0;
            sample_valid_q <= 1'b0;
            sample_out_q   <= AUDIO_MID;
            rd_pend_q      <= 1'b0;
            tick_cnt_q     <= '0;
            state_q        <= FILL;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            commit_ptr_q   <= commit_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            pkt_bad_q      <= pkt_bad_d;
            overflow_q     <= overflow_d;
            underrun_q     <= underrun_d;
            sample_valid_q <= sample_valid_d;
            sample_out_q   <= sample_out_d;
            rd_pend_q      <= rd_pend_d;
            tick_cnt_q     <= tick_cnt_d;
            state_q        <= state_d;
        end
    end

    audio_fifo_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (8)
    ) u_ram (
        .clk     (clk),
        .wr_en   (ram_wr_en),
        .wr_addr (base_wr[ADDR_W-1:0]),
        .wr_data (bus.audio_axiid),
        .rd_en   (ram_rd_en),
        .rd_addr (rd_ptr_q[ADDR_W-1:0]),
        .rd_data (ram_rd_data)
    );

    // ------------------------------------------------------------------
    // Optional PWM output
    // ------------------------------------------------------------------
`ifdef AUDIO_PWM_EN
    logic [7:0] pwm_cnt_q, pwm_cnt_d;
    logic       pwm_out_q, pwm_out_d;

    always_comb begin
        pwm_cnt_d = pwm_cnt_q + 8'd1;
        pwm_out_d = (pwm_cnt_q < sample_out_q);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pwm_cnt_q <= '0;
            pwm_out_q <= 1'b0;
        end else begin
            pwm_cnt_q <= pwm_cnt_d;
            pwm_out_q <= pwm_out_d;
        end
    end

    assign bus.pwm_out = pwm_out_q;
`else
    assign bus.pwm_out = 1'b0;
`endif

    assign bus.sample_out   = sample_out_q;
    assign bus.sample_valid = sample_valid_q;
    assign bus.underrun     = underrun_q;
    assign bus.overflow     = overflow_q;
    assign bus.level        = level;

endmodule
`default_nettype wire
